bcd5_scan_display: RTL and testbench
====================================

# bcd5_scan_display

Time-multiplexed driver for a 5-digit common-anode 7-segment display. It consumes the 20-bit packed BCD word from the 16-bit binary-to-BCD converter, holds a frame-coherent copy, and scans one digit per slot. Each digit gets a guard interval to prevent ghosting, and leading zeros can optionally be blanked. It sits between the converter and the board's segment/anode pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- GUARD, 2: cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-2.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low. One clock; reset is synchronous and active-low.
- bcdout  in  20  packed BCD from the converter; digit k = bcdout[4k+3:4k], digit 0 = units.
- load  in  1  capture strobe; samples bcdout into the pending register.
- blank_lz  in  1  1 = blank leading zeros.
- dp_en  in  5  decimal point enable per digit, bit k = digit k.
- an  out  5  digit enables, active-low, bit k = digit k.
- seg  out  8  active-low segments; seg[0..6] = a..g, seg[7] = dp.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- State:
  - cnt, range 0..SCAN_DIV-1.
  - idx, range 0..4.
  - pending[19:0].
  - shown[19:0].
- Load: when load=1, pending <= bcdout. Any cycle is legal, and the last load in a frame wins.
- Slot advance: when cnt == SCAN_DIV-1:
  - cnt <= 0.
  - idx <= (idx==4) ? 0 : idx+1.
  - Otherwise cnt <= cnt+1.
- Frame boundary (cnt == SCAN_DIV-1 and idx == 4):
  - shown <= pending.
  - frame_tick <= 1.
  - frame_tick is 0 in all other cycles.
  - If load coincides with the boundary, shown takes the pending value from before that edge. The new value is displayed one frame later.
- Decode of digit d = shown[4·idx+3:4·idx], seg[6:0] plus dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, seg[7:0]).
  - d in A..F displays a dash: BF.
- Leading-zero blank: with blank_lz=1, digit k (k = 1..4) is blanked (seg[6:0] all 1) when digits k..4 of shown are all 0. Digit 0 is never blanked. A non-BCD nibble counts as nonzero.
- DP: seg[7] = ~dp_en[idx]. It is independent of blanking.
- Anodes:
  - an = all 1 while cnt < GUARD.
  - Otherwise an = ~(1 << idx).
  - seg is driven regardless of guard.

## Timing
- an, seg and frame_tick are registered.
- an and seg are computed from the (cnt, idx, shown) values present before the same edge, giving a one-cycle lag behind the state.
- Reset (rst_n=0 at an edge):
  - cnt=0, idx=0.
  - pending=0, shown=0.
  - an=5'b11111, seg=8'hFF, frame_tick=0.
- After reset release, edges 1..GUARD keep an=11111.
- At edge GUARD+1, an=11110 and seg shows digit 0 of shown, which is 0 → C0 or C0 with dp.
- Slot length: exactly SCAN_DIV cycles.
- Frame length: 5·SCAN_DIV cycles.
- frame_tick is high for the one cycle after the boundary edge. After reset, the first pulse comes 5·SCAN_DIV edges after release.
- Latency, load to display: the value appears at the next frame boundary plus one cycle. Worst case is 5·SCAN_DIV+1 cycles.
- Reset mid-slot or mid-frame: applies immediately at the next edge. pending and shown clear, and any partially scanned frame is discarded.
- load during reset is ignored.

## Test plan
- Reset hold (SCAN_DIV=8, GUARD=2 for all tests): hold rst_n=0 for 3 cycles with load=1 and bcdout=20'h12345 → an=11111, seg=FF, frame_tick=0. After release, an=11111 for 2 cycles, then 11110 with seg=C0.
- Basic scan: load 20'h12345, blank_lz=0, dp_en=0. After the first frame boundary, slots 0..4 give the following (an / seg after guard), with each an active for exactly 6 cycles per slot and frame_tick pulsing every 40 cycles:
  - 11110 / 92
  - 11101 / 99
  - 11011 / B0
  - 10111 / A4
  - 01111 / F9
- Leading-zero blanking: load 20'h00042 with blank_lz=1:
  - digits 4 and 3 → seg FF.
  - digit 1 → 99.
  - digit 0 → A4.
  - With blank_lz=0, digits 4 and 3 → C0.
  - Load 20'h00000 with blank_lz=1 → only digit 0 shows C0.
- Invalid BCD and dp: load 20'h0A007 with dp_en=5'b00100 and blank_lz=1:
  - digit 3 → BF (dash).
  - digit 4 → FF.
  - digit 2 → 40 (zero with dp; not blanked because digit 3 is nonzero).
  - digit 0 → F8.
- Frame coherence: during slot 2, load 20'h11111, then 20'h22222 in slot 3 → the current frame still shows the old value. The next frame shows all digits A4. Load asserted in the boundary cycle itself is deferred one further frame.
- Reset mid-operation: assert rst_n=0 for 1 cycle mid-slot 3 with 20'h99999 displayed:
  - next edge gives an=11111, seg=FF.
  - scan restarts at digit 0 showing C0.
  - the pending value is lost.

Source files
------------

// File: rtl/bcd5_scan_display.sv
// bcd5_scan_display
//   Time-multiplexed driver for a 5-digit common-anode 7-segment display.
//   A BCD word is captured into a pending register on load and copied to the
//   shown register only at frame boundaries, so a frame never mixes two values.
//   Each digit slot starts with GUARD cycles of all anodes off to avoid ghosting.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bcdout     packed BCD, digit k = bcdout[4k+3:4k], digit 0 = units
//   load       capture strobe for bcdout
//   blank_lz   1 = blank leading zeros
//   dp_en      decimal point enable per digit
//   an         active-low digit enables (registered)
//   seg        active-low segments, seg[6:0]=a..g, seg[7]=dp (registered)
//   frame_tick one-cycle pulse after each frame boundary edge
module bcd5_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] bcdout,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [4:0]  dp_en,
  output logic [4:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [19:0]       pending_q, shown_q;
  logic [4:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              tick_q;

  logic              slot_end, frame_end;
  logic [4:0][3:0]   digs;
  logic [3:0]        dig;
  logic [4:0]        live;   // live[k]: some digit in k..4 is nonzero
  logic              blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;   // non-BCD nibble shows a dash
    endcase
  endfunction

  assign slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == 3'd4);
  assign digs      = shown_q;
  assign dig       = digs[idx_q];

  always_comb begin
    live    = '0;
    live[4] = |digs[4];
    for (int k = 3; k >= 0; k--) live[k] = live[k+1] | (|digs[k]);
  end

  // Units digit is never blanked; a non-BCD nibble counts as nonzero.
  assign blank = blank_lz && (idx_q != 3'd0) && !live[idx_q];

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end
    // Outputs lag the scan state by one cycle: derived from pre-edge values.
    an_d  = (cnt_q < CW'(GUARD)) ? 5'h1F : ~(5'b00001 << idx_q);
    seg_d = {~dp_en[idx_q], blank ? 7'h7F : seg7(dig)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      shown_q   <= '0;
      an_q      <= 5'h1F;
      seg_q     <= 8'hFF;
      tick_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      tick_q <= frame_end;
      if (load)      pending_q <= bcdout;
      // Uses pending from before this edge, so a load on the boundary waits a frame.
      if (frame_end) shown_q   <= pending_q;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd5_scan_display.sv
module tb_bcd5_scan_display;

  localparam int SD = 8;
  localparam int GD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] bcdout;
  logic        load;
  logic        blank_lz;
  logic [4:0]  dp_en;
  logic [4:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int n_chk = 0;
  int n_fail = 0;

  int          hook_j[3];
  logic [19:0] hook_v[3];

  typedef struct {
    logic [19:0]     bcd;
    logic            blz;
    logic [4:0]      dp;
    logic [4:0][7:0] exp;   // exp[k] = seg for digit k
  } vec_t;

  vec_t vecs[8];

  bcd5_scan_display #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk(clk), .rst_n(rst_n), .bcdout(bcdout), .load(load),
    .blank_lz(blank_lz), .dp_en(dp_en), .an(an), .seg(seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [19:0] v);
    bcdout = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic wait_tick(input string nm);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (frame_tick) seen = 1;
    end
    chk({nm, " tick timeout"}, 32'(seen), 32'd1);
  endtask

  // Called right after a frame_tick sample; checks every cycle of the next frame.
  task automatic run_frame(input logic [4:0][7:0] exp, input string nm);
    int slot, c;
    logic [4:0] ea;
    for (int j = 0; j < 5 * SD; j++) begin
      step();
      load = 1'b0;
      for (int h = 0; h < 3; h++)
        if (hook_j[h] == j) begin
          load   = 1'b1;
          bcdout = hook_v[h];
        end
      slot = j / SD;
      c    = j % SD;
      ea   = (c < GD) ? 5'h1F : ~(5'b00001 << slot);
      chk($sformatf("%s j%0d an", nm, j), 32'(an), 32'(ea));
      chk($sformatf("%s j%0d seg", nm, j), 32'(seg), 32'(exp[slot]));
      chk($sformatf("%s j%0d tick", nm, j), 32'(frame_tick), 32'(j == 5 * SD - 1));
    end
    load = 1'b0;
  endtask

  task automatic post_reset(input string nm);
    int first = -1;
    for (int n = 1; n <= 60 && first < 0; n++) begin
      step();
      if (n <= GD) chk($sformatf("%s guard%0d an", nm, n), 32'(an), 32'h1F);
      if (n == GD + 1) begin
        chk({nm, " first an"}, 32'(an), 32'h1E);
        chk({nm, " first seg"}, 32'(seg), 32'hC0);
      end
      if (frame_tick) first = n;
    end
    chk({nm, " first tick edge"}, 32'(first), 32'(5 * SD));
  endtask

  initial begin
    for (int h = 0; h < 3; h++) begin hook_j[h] = -1; hook_v[h] = '0; end

    vecs[0] = '{20'h12345, 1'b0, 5'b00000, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
    vecs[1] = '{20'h00042, 1'b1, 5'b00000, {8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4}};
    vecs[2] = '{20'h00042, 1'b0, 5'b00000, {8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hA4}};
    vecs[3] = '{20'h00000, 1'b1, 5'b00000, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4] = '{20'h0A007, 1'b1, 5'b00100, {8'hFF, 8'hBF, 8'h40, 8'hC0, 8'hF8}};
    vecs[5] = '{20'h12345, 1'b1, 5'b11111, {8'h79, 8'h24, 8'h30, 8'h19, 8'h12}};
    vecs[6] = '{20'hFFFFF, 1'b0, 5'b00000, {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[7] = '{20'h98760, 1'b1, 5'b00001, {8'h90, 8'h80, 8'hF8, 8'h82, 8'h40}};

    // Reset hold with load active: load must be ignored.
    rst_n = 1'b0; load = 1'b1; bcdout = 20'h12345; blank_lz = 1'b0; dp_en = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d an", i), 32'(an), 32'h1F);
      chk($sformatf("rst%0d seg", i), 32'(seg), 32'hFF);
      chk($sformatf("rst%0d tick", i), 32'(frame_tick), 32'd0);
    end
    rst_n = 1'b1; load = 1'b0;
    post_reset("rel");
    run_frame({5{8'hC0}}, "rstload");

    foreach (vecs[i]) begin
      blank_lz = vecs[i].blz;
      dp_en    = vecs[i].dp;
      do_load(vecs[i].bcd);
      wait_tick($sformatf("v%0d", i));
      run_frame(vecs[i].exp, $sformatf("v%0d", i));
    end

    // Frame coherence, including a load on the boundary cycle itself.
    blank_lz = 1'b0; dp_en = '0;
    do_load(20'h33333);
    wait_tick("coh");
    hook_j[0] = 2 * SD;     hook_v[0] = 20'h11111;
    hook_j[1] = 3 * SD;     hook_v[1] = 20'h22222;
    hook_j[2] = 5 * SD - 2; hook_v[2] = 20'h44444;
    run_frame({5{8'hB0}}, "coh_old");
    for (int h = 0; h < 3; h++) hook_j[h] = -1;
    run_frame({5{8'hA4}}, "coh_new");
    run_frame({5{8'h99}}, "coh_bnd");

    // Reset mid-slot 3 with a pending value queued.
    do_load(20'h99999);
    wait_tick("mid");
    do_load(20'h55555);
    repeat (3 * SD + 2) step();
    chk("mid pre an", 32'(an), 32'h17);
    chk("mid pre seg", 32'(seg), 32'h90);
    rst_n = 1'b0;
    step();
    chk("mid rst an", 32'(an), 32'h1F);
    chk("mid rst seg", 32'(seg), 32'hFF);
    chk("mid rst tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    post_reset("mid");
    run_frame({5{8'hC0}}, "mid_lost");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
